// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants for the multi-channel clock divider.
//   CNT_W_DEF  : default width of every divisor and counter
//   DIV_100HZ  : divisor for a 100 Hz tick from the 100 MHz board clock
//   DIV_1KHZ   : divisor for a 1 kHz tick from the 100 MHz board clock
//   DIV_SIM    : short divisor that keeps simulation runs small
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int CNT_W_DEF = 27;
    localparam int DIV_100HZ = 1000000;
    localparam int DIV_1KHZ  = 100000;
    localparam int DIV_SIM   = 4;

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: a programmable-ratio counter that emits a one-cycle
// tick every divisor enabled cycles and a square wave that toggles on each
// tick (period 2*divisor).
// Ports:
//   clk      in   system clock, all logic on posedge
//   reset    in   synchronous active-high reset (restores DEFAULT_DIV)
//   en       in   run enable; when low the count and slow_clk hold
//   load     in   latch div_in and restart the channel from count 0
//   div_in   in   divisor sampled only on load (0 behaves as 1)
//   tick     out  registered one-cycle pulse per divisor period
//   slow_clk out  registered square wave
// -----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DIV_100HZ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    output logic             tick,
    output logic             slow_clk
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_cnt;

    // Terminal count is eff-1, where a zero divisor is treated as one so the
    // channel never stalls; both 0 and 1 therefore give terminal count 0.
    always_comb begin
        last_cnt = '0;
        if (div_q != '0) begin
            last_cnt = div_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= CNT_W'(DEFAULT_DIV);
            cnt      <= '0;
            tick     <= 1'b0;
            slow_clk <= 1'b0;
        end else if (load) begin
            // Load restarts regardless of en, so all channels come out aligned.
            div_q    <= div_in;
            cnt      <= '0;
            tick     <= 1'b0;
            slow_clk <= 1'b0;
        end else if (en) begin
            if (cnt == last_cnt) begin
                cnt      <= '0;
                tick     <= 1'b1;
                slow_clk <= ~slow_clk;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// NUM_CH independent clock-divider channels sharing one clock, reset and
// load strobe. Each channel has its own enable and divisor slice.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   en       in   [NUM_CH]        per-channel run enable
//   load     in   one-cycle strobe: latch div_val into all channels, restart
//   div_val  in   [NUM_CH*CNT_W]  packed divisors, channel i at [i*CNT_W +: CNT_W]
//   tick     out  [NUM_CH]        registered one-cycle ticks
//   slow_clk out  [NUM_CH]        registered 50% duty square waves
// -----------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DIV_100HZ
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    load,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       slow_clk
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .en       (en[i]),
            .load     (load),
            .div_in   (div_val[i*CNT_W +: CNT_W]),
            .tick     (tick[i]),
            .slow_clk (slow_clk[i])
        );
    end

endmodule
